// File: rtl/pool_b_unit.sv
`default_nettype none
// ============================================================================
// Module   : pool_b_unit
// Purpose  : 2x2 stride-2 signed max-pooling stage between two layer memories.
// Revision : 1.0 - initial release
// ============================================================================
module pool_b_unit #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 28,
    parameter int IFM_DEPTH             = 6,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE * IFM_DEPTH),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT * IFM_DEPTH)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    output logic                             end_to_previous,
    input  logic                             end_from_next,
    output logic                             start_to_next,
    output logic                             ifm_enable_read,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read,
    input  logic [DATA_WIDTH-1:0]            ifm_data_in,
    output logic                             ofm_enable_write,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ofm_address_write,
    output logic [DATA_WIDTH-1:0]            ofm_data_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int POS_W = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
    localparam int CH_W  = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;

    localparam logic [POS_W-1:0]                 POS_LAST   = POS_W'(IFM_SIZE_NEXT - 1);
    localparam logic [CH_W-1:0]                  CH_LAST    = CH_W'(IFM_DEPTH - 1);
    localparam logic [ADDRESS_SIZE_IFM-1:0]      ROW_OFFSET = ADDRESS_SIZE_IFM'(IFM_SIZE);
    localparam logic [ADDRESS_SIZE_IFM-1:0]      COL_STEP   = ADDRESS_SIZE_IFM'(2);
    localparam logic [ADDRESS_SIZE_IFM-1:0]      ROW_STEP   = ADDRESS_SIZE_IFM'(IFM_SIZE + 2);
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] OUT_LAST   =
        ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT * IFM_DEPTH - 1);

    logic [1:0]                       state_q, state_d;
    logic                             drain_q, drain_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic [POS_W-1:0]                 r_q, r_d;
    logic [POS_W-1:0]                 c_q, c_d;
    logic [1:0]                       p_q, p_d;
    logic [ADDRESS_SIZE_IFM-1:0]      tl_addr_q, tl_addr_d;
    logic                             rd_valid_q, rd_valid_d;
    logic [1:0]                       rd_phase_q, rd_phase_d;
    logic [DATA_WIDTH-1:0]            max_q, max_d;
    logic                             wr_en_q, wr_en_d;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]            wr_data_q, wr_data_d;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] out_idx_q, out_idx_d;

    logic                             last_read;
    logic [ADDRESS_SIZE_IFM-1:0]      rd_offset;
    logic [DATA_WIDTH-1:0]            window_max;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        case (state_q)
            S_IDLE:  if (start_from_previous) state_d = S_READ;
            S_READ:  if (last_read) state_d = S_DRAIN;
            S_DRAIN: begin
                drain_d = !drain_q;
                if (drain_q) state_d = S_DONE;
            end
            S_DONE:  if (end_from_next) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        end_to_previous = (state_q == S_IDLE);
        start_to_next   = (state_q == S_DONE) && end_from_next;
        ifm_enable_read = (state_q == S_READ);
    end

    // tl_addr tracks the top-left pixel of the current window; stepping past the
    // last column pair (+IFM_SIZE+2) lands on the next row pair or next channel.
    always_comb begin
        ch_d      = ch_q;
        r_d       = r_q;
        c_d       = c_q;
        p_d       = p_q;
        tl_addr_d = tl_addr_q;
        last_read = 1'b0;
        if (state_q == S_READ) begin
            p_d = p_q + 2'd1;
            if (p_q == 2'd3) begin
                if (c_q == POS_LAST) begin
                    c_d       = '0;
                    tl_addr_d = tl_addr_q + ROW_STEP;
                    if (r_q == POS_LAST) begin
                        r_d = '0;
                        if (ch_q == CH_LAST) begin
                            ch_d      = '0;
                            tl_addr_d = '0;
                            last_read = 1'b1;
                        end else begin
                            ch_d = ch_q + 1'b1;
                        end
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d       = c_q + 1'b1;
                    tl_addr_d = tl_addr_q + COL_STEP;
                end
            end
        end
    end

    always_comb begin
        rd_offset = (p_q[1] ? ROW_OFFSET : '0) + ADDRESS_SIZE_IFM'(p_q[0]);
        ifm_address_read = ifm_enable_read ? (tl_addr_q + rd_offset) : '0;
    end

    always_comb begin
        rd_valid_d = ifm_enable_read;
        rd_phase_d = p_q;
        window_max = ((rd_phase_q == 2'd0) || ($signed(ifm_data_in) > $signed(max_q)))
                     ? ifm_data_in : max_q;
        max_d      = rd_valid_q ? window_max : max_q;
        wr_en_d    = rd_valid_q && (rd_phase_q == 2'd3);
        wr_data_d  = wr_en_d ? window_max : wr_data_q;
        wr_addr_d  = wr_en_d ? out_idx_q : wr_addr_q;
        out_idx_d  = out_idx_q;
        if (wr_en_d) begin
            out_idx_d = (out_idx_q == OUT_LAST) ? '0 : out_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ch_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            p_q        <= '0;
            tl_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_phase_q <= '0;
            max_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            out_idx_q  <= '0;
        end else begin
            ch_q       <= ch_d;
            r_q        <= r_d;
            c_q        <= c_d;
            p_q        <= p_d;
            tl_addr_q  <= tl_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_phase_q <= rd_phase_d;
            max_q      <= max_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    assign ofm_enable_write  = wr_en_q;
    assign ofm_address_write = wr_addr_q;
    assign ofm_data_out      = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_b_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_b_unit
// Purpose  : Directed self-checking bench for pool_b_unit (4x4x2 and 28x28x6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_b_unit;

    localparam int DW   = 32;
    localparam int S    = 4;
    localparam int D    = 2;
    localparam int AW   = 5;
    localparam int NAW  = 3;
    localparam int DAW  = 13;
    localparam int DNAW = 11;
    localparam int EXP_DATA [8] = '{5, 7, 13, 15, 21, 23, 29, 31};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           start_from_previous;
    logic           end_from_next;
    logic           end_to_previous, start_to_next, ifm_enable_read, ofm_enable_write;
    logic [AW-1:0]  ifm_address_read;
    logic [DW-1:0]  ifm_data_in;
    logic [NAW-1:0] ofm_address_write;
    logic [DW-1:0]  ofm_data_out;

    logic            start_def;
    logic            etp_def, stn_def, ren_def, wen_def;
    logic [DAW-1:0]  raddr_def;
    logic [DW-1:0]   data_def;
    logic [DNAW-1:0] waddr_def;
    logic [DW-1:0]   wdata_def;

    pool_b_unit #(.DATA_WIDTH(DW), .IFM_SIZE(S), .IFM_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .start_from_previous(start_from_previous), .end_to_previous(end_to_previous),
        .end_from_next(end_from_next), .start_to_next(start_to_next),
        .ifm_enable_read(ifm_enable_read), .ifm_address_read(ifm_address_read),
        .ifm_data_in(ifm_data_in),
        .ofm_enable_write(ofm_enable_write), .ofm_address_write(ofm_address_write),
        .ofm_data_out(ofm_data_out)
    );

    pool_b_unit dut_def (
        .clk(clk), .reset(reset),
        .start_from_previous(start_def), .end_to_previous(etp_def),
        .end_from_next(1'b1), .start_to_next(stn_def),
        .ifm_enable_read(ren_def), .ifm_address_read(raddr_def),
        .ifm_data_in(data_def),
        .ofm_enable_write(wen_def), .ofm_address_write(waddr_def),
        .ofm_data_out(wdata_def)
    );

    int mem [0:31];
    always @(posedge clk) if (ifm_enable_read) ifm_data_in <= mem[ifm_address_read];
    always @(posedge clk) if (ren_def) data_def <= DW'(raddr_def);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int start_cyc = 0;
    int r_addr[$], r_cyc[$], w_addr[$], w_data[$], w_cyc[$], stn_cyc[$];

    always @(negedge clk) begin
        int t;
        t = cyc - start_cyc;
        if (ifm_enable_read) begin
            r_addr.push_back(int'(ifm_address_read));
            r_cyc.push_back(t);
        end
        if (ofm_enable_write) begin
            w_addr.push_back(int'(ofm_address_write));
            w_data.push_back(int'(ofm_data_out));
            w_cyc.push_back(t);
        end
        if (start_to_next) stn_cyc.push_back(t);
    end

    int def_start_cyc = 0;
    int d_reads = 0, d_writes = 0, d_first_w = -1, d_last_w = -1, d_stn = -1;
    int d_last_waddr = -1, d_last_wdata = -1;
    always @(negedge clk) begin
        int t;
        t = cyc - def_start_cyc;
        if (ren_def) d_reads++;
        if (wen_def) begin
            d_writes++;
            if (d_first_w < 0) d_first_w = t;
            d_last_w     = t;
            d_last_waddr = int'(waddr_def);
            d_last_wdata = int'(wdata_def);
        end
        if (stn_def && d_stn < 0) d_stn = t;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int t);
        while (cyc - start_cyc < t) step();
    endtask

    task automatic start_pass();
        r_addr.delete(); r_cyc.delete();
        w_addr.delete(); w_data.delete(); w_cyc.delete(); stn_cyc.delete();
        start_from_previous = 1'b1;
        start_cyc = cyc;
        step();
        start_from_previous = 1'b0;
    endtask

    // Returns positioned in the cycle after start_to_next was seen.
    task automatic wait_stn(input int budget);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (start_to_next) seen = 1'b1;
            step();
            n++;
        end
        check_eq("stn_within_budget", int'(seen), 1);
    endtask

    task automatic check_basic(input string tag);
        int bad = 0;
        int k = 0;
        check_eq($sformatf("%s_nreads", tag), r_addr.size(), 32);
        for (int ch = 0; ch < D; ch++)
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    for (int p = 0; p < 4; p++) begin
                        int e;
                        e = ch*S*S + (2*r + p/2)*S + 2*c + p%2;
                        if (k >= r_addr.size() || r_addr[k] != e || r_cyc[k] != k + 1) bad++;
                        k++;
                    end
        check_eq($sformatf("%s_read_seq_errs", tag), bad, 0);
        check_eq($sformatf("%s_nwrites", tag), w_addr.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < w_addr.size()) begin
                check_eq($sformatf("%s_w%0d_addr", tag, i), w_addr[i], i);
                check_eq($sformatf("%s_w%0d_data", tag, i), w_data[i], EXP_DATA[i]);
                check_eq($sformatf("%s_w%0d_cycle", tag, i), w_cyc[i], 4*i + 6);
            end
        end
        check_eq($sformatf("%s_stn_cycle", tag),
                 (stn_cyc.size() > 0) ? stn_cyc[0] : -1, 35);
    endtask

    initial begin
        int viol;
        int late;
        for (int i = 0; i < 32; i++) mem[i] = i;
        reset = 1'b0;
        start_from_previous = 1'b0;
        start_def = 1'b0;
        end_from_next = 1'b1;
        repeat (3) step();

        @(negedge clk);
        check_eq("rst_end_to_previous", int'(end_to_previous), 1);
        check_eq("rst_start_to_next", int'(start_to_next), 0);
        check_eq("rst_ifm_enable_read", int'(ifm_enable_read), 0);
        check_eq("rst_ofm_enable_write", int'(ofm_enable_write), 0);
        check_eq("rst_ofm_data_out", int'(ofm_data_out), 0);
        step();
        reset = 1'b1;
        step();

        start_pass();
        wait_stn(60);
        check_basic("basic");
        check_eq("basic_etp_after_stn", int'(end_to_previous), 1);

        start_pass();
        wait_stn(60);
        check_basic("b2b");

        mem[0] = -5; mem[1] = -3; mem[4] = -8; mem[5] = -1;
        mem[2] = -7; mem[3] = 0;  mem[6] = -7; mem[7] = -7;
        start_pass();
        wait_stn(60);
        check_eq("signed_w0", (w_data.size() > 0) ? w_data[0] : 999, -1);
        check_eq("signed_w1", (w_data.size() > 1) ? w_data[1] : 999, 0);
        check_eq("signed_w2_unaffected", (w_data.size() > 2) ? w_data[2] : 999, 13);
        for (int i = 0; i < 8; i++) mem[i] = i;

        end_from_next = 1'b0;
        start_pass();
        goto_cycle(35);
        viol = 0;
        for (int j = 0; j < 10; j++) begin
            start_from_previous = (j == 3);
            @(negedge clk);
            if (start_to_next || end_to_previous) viol++;
            step();
        end
        start_from_previous = 1'b0;
        check_eq("bp_wait_violations", viol, 0);
        check_eq("bp_nwrites", w_addr.size(), 8);
        end_from_next = 1'b1;
        @(negedge clk);
        check_eq("bp_stn_on_release", int'(start_to_next), 1);
        step();
        check_eq("bp_idle_after", int'(end_to_previous), 1);
        check_eq("bp_stn_single", int'(start_to_next), 0);
        repeat (3) step();
        check_eq("bp_start_ignored_reads", r_addr.size(), 32);
        check_eq("bp_stn_count", stn_cyc.size(), 1);
        check_eq("bp_stn_cycle", (stn_cyc.size() > 0) ? stn_cyc[0] : -1, 45);

        start_pass();
        goto_cycle(20);
        reset = 1'b0;
        step();
        @(negedge clk);
        check_eq("midrst_end_to_previous", int'(end_to_previous), 1);
        check_eq("midrst_ifm_enable_read", int'(ifm_enable_read), 0);
        check_eq("midrst_ifm_address_read", int'(ifm_address_read), 0);
        check_eq("midrst_ofm_enable_write", int'(ofm_enable_write), 0);
        check_eq("midrst_ofm_address_write", int'(ofm_address_write), 0);
        check_eq("midrst_ofm_data_out", int'(ofm_data_out), 0);
        check_eq("midrst_start_to_next", int'(start_to_next), 0);
        step();
        reset = 1'b1;
        repeat (4) step();
        late = 0;
        foreach (w_cyc[i]) if (w_cyc[i] > 20) late++;
        foreach (r_cyc[i]) if (r_cyc[i] > 20) late++;
        check_eq("midrst_late_activity", late, 0);
        check_eq("midrst_writes_before", w_addr.size(), 4);
        start_pass();
        wait_stn(60);
        check_basic("rerun");

        def_start_cyc = cyc;
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        for (int n = 0; n < 5000 && d_stn < 0; n++) step();
        check_eq("def_stn_cycle", d_stn, 4707);
        check_eq("def_reads", d_reads, 4704);
        check_eq("def_writes", d_writes, 1176);
        check_eq("def_first_write", d_first_w, 6);
        check_eq("def_last_write", d_last_w, 4706);
        check_eq("def_last_waddr", d_last_waddr, 1175);
        check_eq("def_last_wdata", d_last_wdata, 4703);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pool_b_unit.md
# pool_b_unit

2x2, stride-2 signed max-pooling stage placed directly downstream of the convolution block. It reads a complete multi-channel feature map from the conv block's output memory after a `start_from_previous` pulse. It writes the pooled map to the next layer's input memory, then hands off to the next stage with the same start/end handshake the conv block uses.

## Interface
- `DATA_WIDTH`, 32, signed sample width.
- `IFM_SIZE`, 28, input feature-map side; must be even and ≥ 2.
- `IFM_DEPTH`, 6, number of channels.
- `IFM_SIZE_NEXT`, `IFM_SIZE/2`, output side.
- `ADDRESS_SIZE_IFM`, `$clog2(IFM_SIZE*IFM_SIZE*IFM_DEPTH)`.
- `ADDRESS_SIZE_NEXT_IFM`, `$clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT*IFM_DEPTH)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `start_from_previous` in 1: pulse from upstream; the feature map is ready.
- `end_to_previous` out 1: high means upstream may start.
- `end_from_next` in 1: level; downstream is ready to accept.
- `start_to_next` out 1: one-cycle pulse; the pooled map is ready.
- `ifm_enable_read` out 1: read strobe.
- `ifm_address_read` out ADDRESS_SIZE_IFM: read address.
- `ifm_data_in` in DATA_WIDTH: read data, valid exactly 1 cycle after the strobe.
- `ofm_enable_write` out 1: write strobe.
- `ofm_address_write` out ADDRESS_SIZE_NEXT_IFM: write address.
- `ofm_data_out` out DATA_WIDTH: pooled value.

## Operation
- Input layout: `addr = ch*IFM_SIZE² + row*IFM_SIZE + col`.
- Output layout: `ch*IFM_SIZE_NEXT² + r*IFM_SIZE_NEXT + c`, which is sequential 0..N−1 with N = IFM_SIZE_NEXT²·IFM_DEPTH.
- Iteration order: ch outer, then r, then c, then phase p = 0..3.
- Phase p reads `(2r + p[1], 2c + p[0])`: TL, TR, BL, BR.
- Address generation uses counters and adders only; no multipliers.

FSM states: IDLE, READ, DRAIN, DONE.
- **IDLE**: `end_to_previous` = 1. `start_from_previous` = 1 → READ.
- **READ**: one read per cycle, uninterrupted, 4N reads. After the final read (ch, r, c, p all at max) → DRAIN.
- **DRAIN**: exactly 2 cycles, no reads. The last write is issued here. Then → DONE.
- **DONE**: `start_to_next` = `end_from_next` (combinational). When it is 1 → IDLE.

Handshake rules:
- `end_to_previous` = 1 only in IDLE.
- `start_from_previous` is ignored outside IDLE. It is not latched.
- While `end_from_next` stays low, the block waits indefinitely in DONE with all strobes low.

Datapath:
- Phase is delayed 1 cycle to align with returning data.
- Data phase 0: `max ← data`.
- Data phases 1–3: `max ← (data > max) ? data : max`, signed compare.
- On phase-3 data, the registered write fires next cycle:
  - `ofm_data_out` = max of the 4 samples.
  - `ofm_address_write` = output index.
  - `ofm_enable_write` = 1.
- The output index increments after each write and wraps to 0 at N. The read counters also wrap to 0 at the end of the pass.

Reset:
- Any clock edge with `reset` = 0 forces IDLE, zeroes all counters and the max register, and zeroes all strobes, addresses and data outputs.
- This applies mid-operation too: no further writes occur after the reset edge.
- After the reset edge, `end_to_previous` = 1 and every other output is 0.

## Timing
- Cycle 0 = IDLE cycle with `start_from_previous` = 1.
- Reads: cycles 1..4N. Read k is at cycle k+1.
- Output i:
  - TL read at cycle 4i+1.
  - BR data returns at cycle 4i+5.
  - Write at cycle 4i+6.
- Final write at cycle 4N+2, which is the second DRAIN cycle. DONE begins at cycle 4N+3.
- If `end_from_next` = 1 at cycle 4N+3, `start_to_next` pulses that cycle and `end_to_previous` = 1 at 4N+4.
- Defaults: N = 1176.
  - First write at cycle 6.
  - Last read at 4704, last write at 4706.
  - `start_to_next` earliest at 4707.
- Throughput: one output per 4 cycles, with no bubbles between channels.

## Test plan
- **Basic ordering and addresses** (IFM_SIZE=4, IFM_DEPTH=2, `ifm_data_in` = previous read address).
  - Writes (addr:data) are 0:5, 1:7, 2:13, 3:15, 4:21, 5:23, 6:29, 7:31, at cycles 6, 10, …, 34.
  - `start_to_next` pulses at cycle 35 with `end_from_next` held 1.
- **Signed compare**: window −5, −3, −8, −1 → writes −1. Window −7, 0, −7, −7 → writes 0.
- **Downstream backpressure**: hold `end_from_next` = 0 for 10 cycles after DONE entry.
  - `start_to_next` and `end_to_previous` stay 0; a `start_from_previous` pulse in that window is ignored.
  - Raising `end_from_next` gives one `start_to_next` pulse; IDLE follows next cycle.
- **Reset mid-run**: assert `reset` = 0 at cycle 20.
  - Next edge: all outputs 0 and `end_to_previous` = 1.
  - A new start reproduces the scenario-1 results exactly.
- **Back-to-back passes**: a second start right after return to IDLE gives a write address sequence that restarts at 0, and read addresses restart at 0.
- **Defaults** (28/6): exactly 4704 reads and 1176 writes; last write at cycle 4706.
